// File: rtl/data_mem_ctrl_pkg.sv
// Shared sizing and dump-FSM state encoding for the data memory controller.
package mem_defs;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mem_dump_fsm.sv
// Streams a window of the memory array out over a valid/ready port.
// Holds pointer, remaining count and the captured beat; the array lives in the parent.
module mem_dump_fsm #(
    parameter int unsigned ADDR_W = mem_defs::ADDR_W,
    parameter int unsigned DATA_W = mem_defs::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_len,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    import mem_defs::*;

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] data_q;
    logic              zero_done;

    // Pointer wraps modulo DEPTH through natural ADDR_W-bit overflow.
    assign ptr_nxt = ptr + ADDR_W'(1);

    always_comb begin
        rd_addr = ptr_nxt;
        if (state == ST_IDLE) begin
            rd_addr = dump_base;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            data_q    <= '0;
            zero_done <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dump_start) begin
                        if (dump_len != '0) begin
                            state  <= ST_SEND;
                            ptr    <= dump_base;
                            cnt    <= dump_len;
                            data_q <= rd_data;
                        end else begin
                            zero_done <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (dump_ready) begin
                        if (cnt > CNT_ONE) begin
                            ptr    <= ptr_nxt;
                            cnt    <= cnt - CNT_ONE;
                            data_q <= rd_data;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dump_valid = (state == ST_SEND);
    assign dump_busy  = (state == ST_SEND);
    assign dump_done  = (state == ST_DONE) || zero_done;
    assign dump_addr  = ptr;
    assign dump_data  = data_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// 64x8 CPU data/program memory with a preload port and a streaming dump port.
// CPU writes win over loader writes; the dump path only reads the array.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W = mem_defs::ADDR_W,
    parameter int unsigned DATA_W = mem_defs::DATA_W,
    parameter int unsigned DEPTH  = mem_defs::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic [ADDR_W-1:0] adr_bus,
    input  logic [DATA_W-1:0] data_bus_out,
    output logic [DATA_W-1:0] data_bus_in,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_drop,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_len,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    import mem_defs::*;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] dump_rd_addr;
    logic [DATA_W-1:0] dump_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else if (wr_mem) begin
            mem[adr_bus] <= data_bus_out;
        end else if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Any loader write coinciding with a CPU write is lost, regardless of address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_drop <= 1'b0;
        end else begin
            ld_drop <= ld_we && wr_mem;
        end
    end

    assign data_bus_in  = rd_mem ? mem[adr_bus] : '0;
    assign dump_rd_data = mem[dump_rd_addr];

    mem_dump_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dump (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .dump_base  (dump_base),
        .dump_len   (dump_len),
        .dump_ready (dump_ready),
        .rd_addr    (dump_rd_addr),
        .rd_data    (dump_rd_data),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: CPU/loader access, dump streaming, backpressure, reset.
module tb_data_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_mem = 1'b0, wr_mem = 1'b0;
    logic [5:0] adr_bus = '0;
    logic [7:0] data_bus_out = '0;
    logic [7:0] data_bus_in;
    logic       ld_we = 1'b0;
    logic [5:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic       ld_drop;
    logic       dump_start = 1'b0;
    logic [5:0] dump_base = '0;
    logic [6:0] dump_len = '0;
    logic       dump_busy, dump_valid;
    logic       dump_ready = 1'b0;
    logic [5:0] dump_addr;
    logic [7:0] dump_data;
    logic       dump_done;

    data_mem_ctrl #(.ADDR_W(6), .DATA_W(8), .DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .rd_mem(rd_mem), .wr_mem(wr_mem), .adr_bus(adr_bus),
        .data_bus_out(data_bus_out), .data_bus_in(data_bus_in),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_drop(ld_drop),
        .dump_start(dump_start), .dump_base(dump_base), .dump_len(dump_len),
        .dump_busy(dump_busy), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int beats = 0;
    int beat_mark = 0;
    int done_cnt = 0;
    int first_cyc = 0, last_cyc = 0, done_cyc = 0;
    logic [13:0] sb [$];
    logic [13:0] exp_b;
    logic [7:0]  mdl [64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Beats are compared at the negedge preceding the handshake edge.
    always @(negedge clk) begin
        if (dump_valid && dump_ready) begin
            if (sb.size() == 0) begin
                check("sb_extra_beat", sb.size(), 1);
            end else begin
                exp_b = sb.pop_front();
                check("beat_addr", {26'd0, dump_addr}, {26'd0, exp_b[13:8]});
                check("beat_data", {24'd0, dump_data}, {24'd0, exp_b[7:0]});
            end
            if (beats == beat_mark) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
        end
        if (dump_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [7:0] d);
        wr_mem = 1'b1; adr_bus = a; data_bus_out = d;
        tick();
        wr_mem = 1'b0;
        mdl[a] = d;
    endtask

    task automatic ld_write(input logic [5:0] a, input logic [7:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic cpu_read_check(input string tag, input logic [5:0] a, input logic [7:0] e);
        rd_mem = 1'b1; adr_bus = a;
        #1;
        check(tag, {24'd0, data_bus_in}, {24'd0, e});
        rd_mem = 1'b0;
    endtask

    task automatic start_dump(input logic [5:0] base, input logic [6:0] len, input bit push);
        dump_base = base; dump_len = len; dump_start = 1'b1;
        if (push) begin
            for (int k = 0; k < int'(len); k++) begin
                sb.push_back({6'(int'(base) + k), mdl[6'(int'(base) + k)]});
            end
        end
        tick();
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget);
        int n;
        n = 0;
        while (done_cnt == prev && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == prev) check("done_timeout", done_cnt, prev + 1);
    endtask

    int prev_done, prev_beats;
    logic [7:0] held;

    initial begin
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // 1: garbage preload, then asynchronous reset clears everything
        for (int i = 0; i < 64; i++) ld_write(6'(i), 8'($urandom_range(1, 255)));
        #2 rst = 1'b0;
        #1;
        check("rst_busy", {31'd0, dump_busy}, 0);
        check("rst_valid", {31'd0, dump_valid}, 0);
        check("rst_done", {31'd0, dump_done}, 0);
        check("rst_ld_drop", {31'd0, ld_drop}, 0);
        check("rst_dump_addr", {26'd0, dump_addr}, 0);
        check("rst_dump_data", {24'd0, dump_data}, 0);
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) cpu_read_check("rst_word", 6'(i), 8'h00);
        adr_bus = 6'd7;
        #1 check("rd_idle_zero", {24'd0, data_bus_in}, 0);

        // 2: loader image then CPU traffic
        for (int i = 0; i < 64; i++) ld_write(6'(i), 8'(i * 37 + 5));
        cpu_write(6'd40, 8'd55);
        cpu_read_check("rd_40", 6'd40, 8'd55);
        cpu_read_check("rd_0", 6'd0, 8'd5);
        ld_we = 1'b1; ld_addr = 6'd10; ld_data = 8'hAA;
        cpu_write(6'd10, 8'h3C);
        ld_we = 1'b0;
        check("ld_drop_same", {31'd0, ld_drop}, 1);
        cpu_read_check("rd_10_cpu_wins", 6'd10, 8'h3C);
        tick();
        check("ld_drop_clear", {31'd0, ld_drop}, 0);
        ld_we = 1'b1; ld_addr = 6'd11; ld_data = 8'h99;
        cpu_write(6'd12, 8'h77);
        ld_we = 1'b0;
        check("ld_drop_diff", {31'd0, ld_drop}, 1);
        cpu_read_check("rd_11_dropped", 6'd11, mdl[11]);
        cpu_read_check("rd_12", 6'd12, 8'h77);
        rd_mem = 1'b1; wr_mem = 1'b1; adr_bus = 6'd5; data_bus_out = 8'hE1;
        #1 check("rdwr_pre_edge", {24'd0, data_bus_in}, {24'd0, mdl[5]});
        tick();
        rd_mem = 1'b0; wr_mem = 1'b0;
        mdl[5] = 8'hE1;
        cpu_read_check("rdwr_commit", 6'd5, 8'hE1);

        // 3: Fibonacci window, ready tied high
        begin
            logic [7:0] fib [9];
            fib = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21};
            for (int i = 0; i < 9; i++) cpu_write(6'(32 + i), fib[i]);
        end
        dump_ready = 1'b1;
        prev_done = done_cnt; prev_beats = beats; beat_mark = beats;
        start_dump(6'd32, 7'd9, 1'b1);
        check("fib_valid", {31'd0, dump_valid}, 1);
        check("fib_busy", {31'd0, dump_busy}, 1);
        wait_done(prev_done, 30);
        check("fib_beats", beats - prev_beats, 9);
        check("fib_b2b", last_cyc - first_cyc, 8);
        check("fib_done_lat", done_cyc - last_cyc, 1);
        check("fib_sb_empty", sb.size(), 0);
        tick();
        check("fib_idle_done", {31'd0, dump_done}, 0);

        // 4: backpressure with a CPU write to the held address
        dump_ready = 1'b0;
        prev_done = done_cnt; prev_beats = beats;
        start_dump(6'd20, 7'd3, 1'b1);
        check("bp_first_addr", {26'd0, dump_addr}, 20);
        dump_ready = 1'b1;
        tick();
        dump_ready = 1'b0;
        held = mdl[21];
        check("bp_hold_addr0", {26'd0, dump_addr}, 21);
        check("bp_hold_data0", {24'd0, dump_data}, {24'd0, held});
        cpu_write(6'd21, ~held);
        check("bp_hold_addr1", {26'd0, dump_addr}, 21);
        check("bp_hold_data1", {24'd0, dump_data}, {24'd0, held});
        check("bp_hold_valid", {31'd0, dump_valid}, 1);
        dump_ready = 1'b1;
        tick();
        tick();
        dump_ready = 1'b0;
        wait_done(prev_done, 10);
        check("bp_beats", beats - prev_beats, 3);
        check("bp_sb_empty", sb.size(), 0);
        tick();

        // 5: wrap, zero length, start while busy
        dump_ready = 1'b1;
        prev_done = done_cnt; prev_beats = beats;
        start_dump(6'd62, 7'd4, 1'b1);
        wait_done(prev_done, 20);
        check("wrap_beats", beats - prev_beats, 4);
        check("wrap_sb_empty", sb.size(), 0);
        tick();
        prev_done = done_cnt; prev_beats = beats;
        start_dump(6'd3, 7'd0, 1'b0);
        check("len0_done", {31'd0, dump_done}, 1);
        check("len0_valid", {31'd0, dump_valid}, 0);
        check("len0_busy", {31'd0, dump_busy}, 0);
        tick();
        check("len0_done_1cyc", {31'd0, dump_done}, 0);
        check("len0_beats", beats - prev_beats, 0);
        dump_ready = 1'b0;
        prev_done = done_cnt; prev_beats = beats;
        start_dump(6'd10, 7'd3, 1'b1);
        start_dump(6'd50, 7'd5, 1'b0);
        check("busy_ign_addr", {26'd0, dump_addr}, 10);
        dump_ready = 1'b1;
        wait_done(prev_done, 20);
        check("busy_ign_beats", beats - prev_beats, 3);
        check("busy_ign_sb", sb.size(), 0);
        tick();
        check("busy_ign_idle", {31'd0, dump_busy}, 0);

        // 6: reset after two of five beats
        prev_done = done_cnt; prev_beats = beats;
        start_dump(6'd0, 7'd5, 1'b1);
        tick();
        tick();
        check("mid_beats", beats - prev_beats, 2);
        rst = 1'b0;
        #1;
        check("mid_valid", {31'd0, dump_valid}, 0);
        check("mid_busy", {31'd0, dump_busy}, 0);
        check("mid_done", {31'd0, dump_done}, 0);
        sb.delete();
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("mid_no_done", done_cnt, prev_done);
        cpu_write(6'd3, 8'h5A);
        prev_done = done_cnt; prev_beats = beats;
        start_dump(6'd2, 7'd3, 1'b1);
        wait_done(prev_done, 20);
        check("post_rst_beats", beats - prev_beats, 3);
        check("post_rst_sb", sb.size(), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
